// File: rtl/draw_board_grid.sv
// Minesweeper grid overlay: draws tile grid, cursor frame and tile colours over a VGA stream.
// Two register stages; all timing fields leave exactly two clocks after they arrive.
module draw_board_grid #(
    parameter int          BOARD_X   = 192,
    parameter int          BOARD_Y   = 44,
    parameter int          TILE_SIZE = 32,
    parameter int          TILES_X   = 16,
    parameter int          TILES_Y   = 16,
    parameter logic [11:0] GRID_RGB  = 12'h444,
    parameter logic [11:0] CUR_RGB   = 12'hff0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_hcount,
    input  logic [10:0] i_vcount,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_hblnk,
    input  logic        i_vblnk,
    input  logic [11:0] i_rgb,
    output logic [10:0] o_hcount,
    output logic [10:0] o_vcount,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblnk,
    output logic        o_vblnk,
    output logic [11:0] o_rgb,
    output logic [7:0]  o_tile_addr,
    input  logic [2:0]  i_tile_data,
    input  logic [3:0]  i_cursor_col,
    input  logic [3:0]  i_cursor_row
);

    localparam int          OW       = $clog2(TILE_SIZE);
    localparam logic [OW-1:0] OFF_LAST = OW'(TILE_SIZE - 1);
    localparam logic [3:0]  COL_LAST = 4'(TILES_X - 1);
    localparam logic [3:0]  ROW_LAST = 4'(TILES_Y - 1);
    localparam logic [10:0] X_START  = 11'(BOARD_X);
    localparam logic [10:0] X_END    = 11'(BOARD_X + TILES_X * TILE_SIZE);
    localparam logic [10:0] Y_START  = 11'(BOARD_Y);
    localparam logic [10:0] Y_END    = 11'(BOARD_Y + TILES_Y * TILE_SIZE);

    logic [10:0]   r_hcount, r_vcount;
    logic          r_hsync, r_vsync, r_hblnk, r_vblnk;
    logic [11:0]   r_rgb;
    logic          r_in_board, r_frame_ok, r_cur_hit;
    logic [OW-1:0] r_xoff, r_yoff;
    logic [3:0]    r_col, r_row;
    logic [7:0]    r_tile_addr;

    logic [10:0]   r_out_hcount, r_out_vcount;
    logic          r_out_hsync, r_out_vsync, r_out_hblnk, r_out_vblnk;
    logic [11:0]   r_out_rgb;

    logic          w_h_in, w_v_in, w_in_board, w_at_left, w_at_top, w_cur_hit, w_frame_ok_next;
    logic [OW-1:0] w_xoff_next, w_yoff_next;
    logic [3:0]    w_col_next, w_row_next;
    logic [7:0]    w_addr_next;
    logic [11:0]   w_tile_rgb, w_rgb_next;

    assign w_h_in     = (i_hcount >= X_START) && (i_hcount < X_END);
    assign w_v_in     = (i_vcount >= Y_START) && (i_vcount < Y_END);
    assign w_in_board = w_h_in && w_v_in;
    assign w_at_left  = (i_hcount == X_START);
    assign w_at_top   = (i_vcount == Y_START);

    // Column/row tracked by offset counters that wrap per tile; saturate at the last tile.
    always_comb begin
        w_xoff_next     = r_xoff;
        w_col_next      = r_col;
        w_yoff_next     = r_yoff;
        w_row_next      = r_row;
        w_frame_ok_next = r_frame_ok;
        if (w_at_left) begin
            w_xoff_next = '0;
            w_col_next  = '0;
            if (w_at_top) begin
                w_yoff_next     = '0;
                w_row_next      = '0;
                w_frame_ok_next = 1'b1;
            end else if (w_v_in) begin
                if (r_yoff == OFF_LAST) begin
                    w_yoff_next = '0;
                    if (r_row != ROW_LAST)
                        w_row_next = r_row + 4'd1;
                end else begin
                    w_yoff_next = r_yoff + OW'(1);
                end
            end
        end else if (w_in_board) begin
            if (r_xoff == OFF_LAST) begin
                w_xoff_next = '0;
                if (r_col != COL_LAST)
                    w_col_next = r_col + 4'd1;
            end else begin
                w_xoff_next = r_xoff + OW'(1);
            end
        end
    end

    assign w_addr_next = 8'(w_row_next) * 8'(TILES_X) + 8'(w_col_next);
    assign w_cur_hit   = (i_cursor_col == w_col_next) && (i_cursor_row == w_row_next)
                         && ({1'b0, i_cursor_col} < 5'(TILES_X))
                         && ({1'b0, i_cursor_row} < 5'(TILES_Y));

    // r_tile_addr doubles as the board RAM's address register, so tile data lines up with stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_hblnk     <= 1'b0;
            r_vblnk     <= 1'b0;
            r_rgb       <= '0;
            r_in_board  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_cur_hit   <= 1'b0;
            r_xoff      <= '0;
            r_yoff      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_tile_addr <= '0;
        end else begin
            r_hcount    <= i_hcount;
            r_vcount    <= i_vcount;
            r_hsync     <= i_hsync;
            r_vsync     <= i_vsync;
            r_hblnk     <= i_hblnk;
            r_vblnk     <= i_vblnk;
            r_rgb       <= i_rgb;
            r_in_board  <= w_in_board;
            r_frame_ok  <= w_frame_ok_next;
            r_cur_hit   <= w_cur_hit;
            r_xoff      <= w_xoff_next;
            r_yoff      <= w_yoff_next;
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_tile_addr <= w_addr_next;
        end
    end

    always_comb begin
        case (i_tile_data)
            3'd1:    w_tile_rgb = 12'hccc;
            3'd2:    w_tile_rgb = 12'hf00;
            3'd3:    w_tile_rgb = 12'h000;
            default: w_tile_rgb = 12'h999;
        endcase
        w_rgb_next = w_tile_rgb;
        if (r_hblnk || r_vblnk)
            w_rgb_next = 12'h000;
        else if (!r_in_board || !r_frame_ok)
            w_rgb_next = r_rgb;
        else if ((r_xoff == '0) || (r_yoff == '0))
            w_rgb_next = GRID_RGB;
        else if (r_cur_hit && ((r_xoff == OW'(1)) || (r_xoff == OFF_LAST) ||
                               (r_yoff == OW'(1)) || (r_yoff == OFF_LAST)))
            w_rgb_next = CUR_RGB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_hcount <= '0;
            r_out_vcount <= '0;
            r_out_hsync  <= 1'b0;
            r_out_vsync  <= 1'b0;
            r_out_hblnk  <= 1'b0;
            r_out_vblnk  <= 1'b0;
            r_out_rgb    <= '0;
        end else begin
            r_out_hcount <= r_hcount;
            r_out_vcount <= r_vcount;
            r_out_hsync  <= r_hsync;
            r_out_vsync  <= r_vsync;
            r_out_hblnk  <= r_hblnk;
            r_out_vblnk  <= r_vblnk;
            r_out_rgb    <= w_rgb_next;
        end
    end

    assign o_hcount    = r_out_hcount;
    assign o_vcount    = r_out_vcount;
    assign o_hsync     = r_out_hsync;
    assign o_vsync     = r_out_vsync;
    assign o_hblnk     = r_out_hblnk;
    assign o_vblnk     = r_out_vblnk;
    assign o_rgb       = r_out_rgb;
    assign o_tile_addr = r_tile_addr;

endmodule

// File: tb/tb_draw_board_grid.sv
// Directed and scanned-stream bench for draw_board_grid with an independent div/mod pixel model.
// The board RAM is modelled as a lookup on the DUT's registered tile address.
module tb_draw_board_grid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcountIn = '0, vcountIn = '0;
    logic        hsyncIn = 1'b0, vsyncIn = 1'b0, hblnkIn = 1'b0, vblnkIn = 1'b0;
    logic [11:0] rgbIn = '0;
    logic [10:0] hcountOut, vcountOut;
    logic        hsyncOut, vsyncOut, hblnkOut, vblnkOut;
    logic [11:0] rgbOut;
    logic [7:0]  tileAddr;
    logic [2:0]  tileData;
    logic [3:0]  cursorCol = 4'd5, cursorRow = 4'd5;
    logic [2:0]  board [256];

    int vectors = 0;
    int miscompares = 0;

    bit          modelFrameOk = 1'b0;
    bit          prevValid = 1'b0;
    logic [37:0] prevExp = '0;
    int          prevH = 0, prevV = 0;

    always #5 clk = ~clk;

    assign tileData = board[tileAddr];

    draw_board_grid dut (
        .clk          (clk),
        .rst          (rst),
        .i_hcount     (hcountIn),
        .i_vcount     (vcountIn),
        .i_hsync      (hsyncIn),
        .i_vsync      (vsyncIn),
        .i_hblnk      (hblnkIn),
        .i_vblnk      (vblnkIn),
        .i_rgb        (rgbIn),
        .o_hcount     (hcountOut),
        .o_vcount     (vcountOut),
        .o_hsync      (hsyncOut),
        .o_vsync      (vsyncOut),
        .o_hblnk      (hblnkOut),
        .o_vblnk      (vblnkOut),
        .o_rgb        (rgbOut),
        .o_tile_addr  (tileAddr),
        .i_tile_data  (tileData),
        .i_cursor_col (cursorCol),
        .i_cursor_row (cursorRow)
    );

    wire [37:0] outBundle = {hcountOut, vcountOut, hsyncOut, vsyncOut, hblnkOut, vblnkOut, rgbOut};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] tileColour(input logic [2:0] d);
        case (d)
            3'd1:    return 12'hccc;
            3'd2:    return 12'hf00;
            3'd3:    return 12'h000;
            default: return 12'h999;
        endcase
    endfunction

    // One pixel per clock: the previous pixel's outputs and this pixel's tile address are checked.
    task automatic applyStimulus(input int h, input int v, input bit hs, input bit vs,
                                 input bit hb, input bit vb, input logic [11:0] rgb);
        bit          inB;
        int          xo, yo, col, row;
        logic [11:0] er;
        logic [7:0]  eAddr;
        logic [37:0] exp;
        @(negedge clk);
        hcountIn = 11'(h);
        vcountIn = 11'(v);
        hsyncIn  = hs;
        vsyncIn  = vs;
        hblnkIn  = hb;
        vblnkIn  = vb;
        rgbIn    = rgb;
        inB = (h >= 192) && (h < 704) && (v >= 44) && (v < 556);
        if (h == 192 && v == 44)
            modelFrameOk = 1'b1;
        xo = 0; yo = 0; col = 0; row = 0;
        if (inB) begin
            xo  = (h - 192) % 32;
            yo  = (v - 44) % 32;
            col = (h - 192) / 32;
            row = (v - 44) / 32;
        end
        eAddr = 8'(row * 16 + col);
        if (hb || vb)
            er = 12'h000;
        else if (!inB || !modelFrameOk)
            er = rgb;
        else if (xo == 0 || yo == 0)
            er = 12'h444;
        else if (int'(cursorCol) == col && int'(cursorRow) == row &&
                 (xo == 1 || xo == 31 || yo == 1 || yo == 31))
            er = 12'hff0;
        else
            er = tileColour(board[eAddr]);
        exp = {11'(h), 11'(v), hs, vs, hb, vb, er};
        @(posedge clk);
        #1;
        if (prevValid)
            checkOutput($sformatf("out(%0d,%0d)", prevH, prevV), 64'(outBundle), 64'(prevExp));
        if (inB && modelFrameOk)
            checkOutput($sformatf("addr(%0d,%0d)", h, v), 64'(tileAddr), 64'(eAddr));
        prevExp   = exp;
        prevH     = h;
        prevV     = v;
        prevValid = 1'b1;
    endtask

    task automatic pix(input int h, input int v);
        applyStimulus(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic feedLeft(input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            pix(192, v);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_out", 64'(outBundle), 64'd0);
        checkOutput("rst_addr", 64'(tileAddr), 64'd0);
        rst = 1'b0;
        modelFrameOk = 1'b0;
        prevValid    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            board[i] = 3'(i % 8);
        board[35] = 3'd2;
        board[85] = 3'd1;
        doReset();

        // Before any frame start the overlay must stay transparent.
        applyStimulus(300, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        pix(301, 100);
        checkOutput("pre_frame_pass", 64'(rgbOut), 64'h123);

        pix(191, 44);
        pix(192, 44);
        checkOutput("t1_addr", 64'(tileAddr), 64'd0);
        pix(193, 44);
        checkOutput("t1_grid", 64'(rgbOut), 64'h444);

        feedLeft(45, 108);
        for (int h = 192; h <= 289; h++)
            pix(h, 109);
        checkOutput("t2_addr", 64'(tileAddr), 64'd35);
        pix(290, 109);
        checkOutput("t2_flag", 64'(rgbOut), 64'hf00);

        feedLeft(110, 208);
        for (int h = 192; h <= 353; h++)
            pix(h, 209);
        pix(354, 209);
        checkOutput("t3_cursor", 64'(rgbOut), 64'hff0);

        cursorCol = 4'd6;
        for (int h = 192; h <= 353; h++)
            pix(h, 210);
        applyStimulus(354, 210, 1'b0, 1'b0, 1'b1, 1'b0, 12'habc);
        checkOutput("t3_no_cursor", 64'(rgbOut), 64'hccc);
        pix(355, 210);
        checkOutput("t4_hblank", 64'(rgbOut), 64'h000);

        applyStimulus(100, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h888);
        pix(101, 300);
        checkOutput("t4_outside", 64'(rgbOut), 64'h888);

        feedLeft(211, 300);
        for (int h = 192; h <= 250; h++)
            pix(h, 301);
        doReset();
        applyStimulus(251, 301, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5a5);
        pix(252, 301);
        checkOutput("t5_pass", 64'(rgbOut), 64'h5a5);
        for (int h = 253; h <= 300; h++)
            pix(h, 301);
        feedLeft(302, 560);
        pix(190, 40);
        pix(192, 44);
        checkOutput("t5_addr", 64'(tileAddr), 64'd0);
        pix(193, 44);
        checkOutput("t5_grid", 64'(rgbOut), 64'h444);

        // Scanned frames: every line touches the left edge, some lines cross the whole board.
        for (int f = 0; f < 3; f++) begin
            pix(800, 600);
            for (int i = 0; i < 256; i++)
                board[i] = 3'($urandom);
            for (int v = 40; v <= 560; v++) begin
                cursorCol = 4'($urandom);
                cursorRow = (v >= 44 && v < 556) ? 4'((v - 44) / 32) : 4'($urandom);
                if ((v % 41 == 7) || v == 44 || v == 555 || v == 556) begin
                    for (int h = 186; h <= 710; h++)
                        applyStimulus(h, v, 1'($urandom), 1'($urandom),
                                      $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                                      12'($urandom));
                end else begin
                    for (int h = 186; h <= 195; h++)
                        applyStimulus(h, v, 1'($urandom), 1'($urandom),
                                      $urandom_range(0, 19) == 0, 1'b0, 12'($urandom));
                end
            end
        end
        pix(800, 600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
